// File: rtl/rc4_sched_pkg.sv
// rc4_sched_pkg: shared state encoding and default key width for the key chunk scheduler.
package rc4_sched_pkg;
   localparam int KEY_W_DEF = 24;
   typedef enum logic [2:0] {
      S_IDLE,
      S_DISPATCH,
      S_DRAIN,
      S_FOUND,
      S_EXHAUSTED
   } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr, wrapping around.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);
   logic hit;
   always_comb begin
      grant = '0;
      hit   = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!hit && req[(int'(ptr) + k) % N]) begin
            grant[(int'(ptr) + k) % N] = 1'b1;
            hit = 1'b1;
         end
      end
   end
endmodule

// File: rtl/key_chunk_scheduler.sv
// key_chunk_scheduler: hands out fixed-size key chunks round-robin to decryption cores
// and latches the first reported matching key.
module key_chunk_scheduler
   import rc4_sched_pkg::*;
#(
   parameter int                 NUM_CORES  = 4,
   parameter int                 KEY_W      = KEY_W_DEF,
   parameter int                 CHUNK_LOG2 = 16,
   parameter logic [KEY_W-1:0]   MAX_KEY    = 24'h3FFFFF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         abort,
   input  logic [NUM_CORES-1:0]         core_req,
   input  logic [NUM_CORES-1:0]         core_found,
   input  logic [NUM_CORES*KEY_W-1:0]   core_key,
   output logic [NUM_CORES-1:0]         grant,
   output logic [KEY_W-1:0]             chunk_base,
   output logic                         core_halt,
   output logic                         busy,
   output logic                         found,
   output logic                         exhausted,
   output logic [KEY_W-1:0]             found_key,
   output logic [$clog2(NUM_CORES)-1:0] found_core
);
   localparam int PW = $clog2(NUM_CORES);
   localparam logic [KEY_W:0] STEP = {{KEY_W{1'b0}}, 1'b1} << CHUNK_LOG2;
   localparam logic [KEY_W:0] LAST = {1'b0, MAX_KEY} + 1'b1 - STEP;

   state_t               state, state_n;
   logic [KEY_W:0]       next_base;
   logic [PW-1:0]        rr_ptr, rr_nxt, gidx, fidx;
   logic [NUM_CORES-1:0] pending, arb_grant;
   logic [KEY_W-1:0]     fkey;
   logic                 halt_q, active, any_found, do_abort, do_init, done;

   rr_arbiter #(.N(NUM_CORES), .PW(PW)) u_arb (
      .req   (core_req),
      .ptr   (rr_ptr),
      .grant (arb_grant)
   );

   assign active    = state == S_DISPATCH || state == S_DRAIN;
   assign done      = state == S_FOUND || state == S_EXHAUSTED;
   assign any_found = |core_found;
   assign do_abort  = abort && state != S_IDLE;
   assign do_init   = start && !abort && (state == S_IDLE || done);

   // Outputs are forced low while reset is held so nothing leaks before the reset edge.
   assign grant      = (reset && state == S_DISPATCH && !any_found) ? arb_grant : '0;
   assign chunk_base = |grant ? next_base[KEY_W-1:0] : '0;
   assign busy       = reset && active;
   assign found      = reset && state == S_FOUND;
   assign exhausted  = reset && state == S_EXHAUSTED;
   assign core_halt  = reset && (halt_q || done);
   assign rr_nxt     = gidx == PW'(NUM_CORES - 1) ? '0 : gidx + 1'b1;

   // Descending scan so the lowest-index finder wins.
   always_comb begin
      gidx = '0;
      fidx = '0;
      fkey = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (grant[i]) gidx = PW'(i);
         if (core_found[i]) begin
            fidx = PW'(i);
            fkey = core_key[i*KEY_W +: KEY_W];
         end
      end
   end

   always_comb begin
      state_n = state;
      if (do_abort) state_n = S_IDLE;
      else if (do_init) state_n = S_DISPATCH;
      else if (active && any_found) state_n = S_FOUND;
      else if (state == S_DISPATCH && |grant && next_base == LAST) state_n = S_DRAIN;
      else if (state == S_DRAIN && pending == '0 && &core_req) state_n = S_EXHAUSTED;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         next_base  <= '0;
         rr_ptr     <= '0;
         pending    <= '0;
         found_key  <= '0;
         found_core <= '0;
         halt_q     <= 1'b0;
      end else begin
         state  <= state_n;
         halt_q <= do_abort;
         if (do_abort) begin
            pending <= '0;
         end else if (do_init) begin
            next_base  <= '0;
            rr_ptr     <= '0;
            pending    <= '0;
            found_key  <= '0;
            found_core <= '0;
         end else begin
            pending <= (pending | grant) & ~(core_req & ~grant);
            if (|grant) begin
               next_base <= next_base + STEP;
               rr_ptr    <= rr_nxt;
            end
            if (active && any_found) begin
               found_key  <= fkey;
               found_core <= fidx;
            end
         end
      end
   end
endmodule

// File: tb/tb_key_chunk_scheduler.sv
// tb_key_chunk_scheduler: directed vectors for the 4-core, 4-chunk configuration.
module tb_key_chunk_scheduler;
   logic        clk = 1'b0;
   logic        reset, start, abort;
   logic [3:0]  core_req, core_found, grant;
   logic [95:0] core_key;
   logic [23:0] chunk_base, found_key;
   logic        core_halt, busy, found, exhausted;
   logic [1:0]  found_core;
   int          n_vec = 0, n_err = 0;

   key_chunk_scheduler #(
      .NUM_CORES(4), .KEY_W(24), .CHUNK_LOG2(20), .MAX_KEY(24'h3FFFFF)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .core_req(core_req), .core_found(core_found), .core_key(core_key),
      .grant(grant), .chunk_base(chunk_base), .core_halt(core_halt),
      .busy(busy), .found(found), .exhausted(exhausted),
      .found_key(found_key), .found_core(found_core)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic grant_is(input string tag, input logic [3:0] g, input logic [23:0] b);
      #2;
      chk({tag, "_grant"}, 32'(grant), 32'(g));
      chk({tag, "_base"}, 32'(chunk_base), 32'(b));
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      core_req = '0; core_found = '0; core_key = '0;
      step(); step();
      #2;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_base", 32'(chunk_base), 0);
      chk("rst_status", {28'd0, core_halt, busy, found, exhausted}, 0);
      reset = 1'b1;
      core_req = 4'b1111; start = 1'b1;
      step(); start = 1'b0;
      chk("disp_busy", 32'(busy), 1);
      grant_is("g0", 4'b0001, 24'h000000); step(); core_req = 4'b1110;
      grant_is("g1", 4'b0010, 24'h100000); step(); core_req = 4'b1100;
      grant_is("g2", 4'b0100, 24'h200000); step(); core_req = 4'b1000;
      grant_is("g3", 4'b1000, 24'h300000); step(); core_req = 4'b0000;
      grant_is("drain", 4'b0000, 24'h0);
      chk("drain_busy", {30'd0, busy, exhausted}, 32'b10);
      core_req = 4'b1111;
      grant_is("drain_req", 4'b0000, 24'h0);
      step();
      chk("drain_pend", {30'd0, busy, exhausted}, 32'b10);
      step();
      grant_is("exh", 4'b0000, 24'h0);
      chk("exh_status", {28'd0, core_halt, busy, found, exhausted}, 32'b1001);

      start = 1'b1; step(); start = 1'b0;
      core_found = 4'b0110;
      core_key = {24'h0, 24'h2000FF, 24'h1234AB, 24'h0};
      grant_is("found_prio", 4'b0000, 24'h0);
      step(); core_found = '0;
      chk("found_core", 32'(found_core), 1);
      chk("found_key", 32'(found_key), 32'h1234AB);
      chk("found_status", {28'd0, core_halt, busy, found, exhausted}, 32'b1010);
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort_keep_key", 32'(found_key), 32'h1234AB);
      chk("abort_found_status", {28'd0, core_halt, busy, found, exhausted}, 32'b1000);
      step();
      chk("idle_halt", 32'(core_halt), 0);

      abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
      chk("start_abort", {30'd0, core_halt, busy}, 0);

      core_req = 4'b0001; start = 1'b1; step(); start = 1'b0;
      grant_is("rr_a", 4'b0001, 24'h000000); step();
      grant_is("rr_b", 4'b0001, 24'h100000); step();
      core_req = 4'b1001;
      grant_is("rr_c", 4'b1000, 24'h200000); step();
      core_req = 4'b0001;
      grant_is("rr_d", 4'b0001, 24'h300000); step();
      core_req = 4'b0000;
      grant_is("drain2", 4'b0000, 24'h0);
      chk("drain2_halt", {30'd0, core_halt, busy}, 32'b01);
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort_pulse", {28'd0, core_halt, busy, found, exhausted}, 32'b1000);
      step();
      chk("abort_pulse_end", 32'(core_halt), 0);
      core_req = 4'b0010; start = 1'b1; step(); start = 1'b0;
      grant_is("restart", 4'b0010, 24'h000000); step();
      core_req = 4'b0100;
      grant_is("mid", 4'b0100, 24'h100000);
      reset = 1'b0;
      grant_is("in_rst", 4'b0000, 24'h0);
      step(); reset = 1'b1; core_req = '0;
      #2;
      chk("post_rst_status", {28'd0, core_halt, busy, found, exhausted}, 0);
      chk("post_rst_key", {6'd0, found_core, found_key}, 0);
      core_req = 4'b1111; start = 1'b1; step(); start = 1'b0;
      grant_is("rst_restart", 4'b0001, 24'h000000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/key_chunk_scheduler.md
KEY_CHUNK_SCHEDULER -- requirements
Module: key_chunk_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 4: number of decryption cores served.
REQ-002 Parameter KEY_W, default 24: secret-key width.
REQ-003 Parameter CHUNK_LOG2, default 16: log2 of keys per chunk.
REQ-004 Parameter MAX_KEY, default 24'h3FFFFF: last key searched; MAX_KEY+1 SHALL be a multiple of 2^CHUNK_LOG2.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; begins a new search.
REQ-008 abort  in  1  one-cycle pulse; cancels the search.
REQ-009 core_req  in  NUM_CORES  level; core i is idle and its previous chunk, if any, finished without a match.
REQ-010 core_found  in  NUM_CORES  one-cycle pulse; core i matched a key.
REQ-011 core_key  in  NUM_CORES*KEY_W  core i's matching key in bits [i*KEY_W +: KEY_W]; valid with core_found[i].
REQ-012 grant  out  NUM_CORES  one-hot; core i receives chunk_base this cycle.
REQ-013 chunk_base  out  KEY_W  first key of the granted chunk.
REQ-014 core_halt  out  1  broadcast stop to all cores.
REQ-015 busy, found, exhausted  out  1 each  status levels.
REQ-016 found_key  out  KEY_W  winning key; found_core  out  $clog2(NUM_CORES)  winning core index.

Function
REQ-017 States SHALL be IDLE, DISPATCH, DRAIN, FOUND, EXHAUSTED.
REQ-018 IDLE + start: next_base=0, rr_ptr=0, pending=0, found_key=0, found_core=0; go to DISPATCH next cycle.
REQ-019 In DISPATCH, grant SHALL be combinational: one-hot on the first core_req bit at or after rr_ptr (round-robin); otherwise zero.
REQ-020 chunk_base SHALL equal registered next_base whenever grant is non-zero; otherwise it is 0.
REQ-021 On an edge with grant[i]=1: pending[i]=1, next_base += 2^CHUNK_LOG2, rr_ptr=(i+1) mod NUM_CORES. Each core drops core_req after the granting edge.
REQ-022 On an edge with core_req[i]=1 and grant[i]=0: pending[i]=0 (chunk completed, no match).
REQ-023 next_base SHALL be KEY_W+1 bits. The grant that issues base MAX_KEY+1-2^CHUNK_LOG2 moves the state to DRAIN; no base above MAX_KEY is ever issued.
REQ-024 DRAIN: grant=0; go to EXHAUSTED when pending==0 and core_req is all ones.
REQ-025 Any core_found bit in DISPATCH or DRAIN has priority: grant=0 that cycle. The next edge latches the lowest-index asserting core into found_core and its core_key into found_key, then enters FOUND.
REQ-026 core_halt SHALL be 1 in FOUND and EXHAUSTED, and for exactly one cycle after abort; otherwise 0.
REQ-027 found=1 only in FOUND; exhausted=1 only in EXHAUSTED; busy=1 in DISPATCH and DRAIN.
REQ-028 FOUND and EXHAUSTED hold until start, which re-initialises as in REQ-018.
REQ-029 abort in DISPATCH, DRAIN, FOUND or EXHAUSTED returns to IDLE, clears pending and keeps found_key. abort in IDLE has no effect.
REQ-030 If start and abort arrive together, abort wins.
REQ-031 start in DISPATCH or DRAIN SHALL be ignored.
REQ-032 core_found in IDLE, FOUND or EXHAUSTED SHALL be ignored.

Reset
REQ-033 reset=0 at an edge: state=IDLE; next_base, rr_ptr, pending, found_key, found_core = 0.
REQ-034 During and after reset, grant=0, chunk_base=0, core_halt=0, busy=found=exhausted=0.
REQ-035 Reset overrides every other input, including in mid-search.

Structure
REQ-036 Package rc4_sched_pkg SHALL hold the state enum typedef and the KEY_W default constant.
REQ-037 Round-robin selection SHALL be the sub-module rr_arbiter (inputs req and ptr, output one-hot grant). The top level holds the FSM, the base counter, pending and the latches.

Verification (NUM_CORES=4, CHUNK_LOG2=20, MAX_KEY=24'h3FFFFF; 4 chunks)
REQ-038 Reset, then start, with core_req=4'b1111 -> grants 0001, 0010, 0100, 1000 on consecutive cycles with bases 0x000000, 0x100000, 0x200000, 0x300000, then DRAIN.
REQ-039 All cores re-raise core_req after their chunks -> EXHAUSTED, exhausted=1, core_halt=1, and no fifth grant.
REQ-040 core_found=4'b0110 with keys 0x1234AB (core 1) and 0x2000FF (core 2) -> found_core=1, found_key=0x1234AB, found=1, core_halt=1, grant=0 that cycle.
REQ-041 core_req=4'b0001 only, rr_ptr=1 -> grant=0001; then core_req=4'b1001 -> grant=1000.
REQ-042 abort during DRAIN -> core_halt pulses 1 cycle, state IDLE, busy=0; a later start reissues base 0x000000.
REQ-043 reset=0 for one cycle mid-DISPATCH -> all outputs 0 on the next cycle; the following start restarts at base 0.
